lcd_reader: RTL and testbench

- 4-bit HD44780-style bus read engine: drives RS/RW/E, captures the high then low nibble from the LCD data pins, returns one byte.
- Read types: busy-flag/address-counter (RS=0) or data RAM (RS=1); optional busy-flag polling until BF clears.
- Sits beside the LCD write controller; top-level mux hands lcd_rs/lcd_e to this block while lcd_bus_req=1. The pad driver releases d[7:4] while lcd_rw=1.

---
 rtl/lcd_reader.sv | 222 ++++++++++++++++++++++
 tb/tb_lcd_reader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_reader.sv
// lcd_reader: 4-bit HD44780-style read engine. Drives RS/RW/E, captures the
// high then the low nibble from d[7:4] and returns one byte. A busy-flag read
// can optionally be repeated until BF clears, bounded by MAX_POLLS.
// Optional build macro LCD_READ_SYNC_EN: adds a 2-flop synchronizer on
// lcd_d_in and stretches each E-high phase by two cycles to cover its delay.
module lcd_reader #(
    parameter int E_SETUP   = 2,
    parameter int E_HIGH    = 15,
    parameter int E_LOW     = 10,
    parameter int MAX_POLLS = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req,
    input  logic       req_rs,
    input  logic       poll,
    output logic       ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy_flag,
    output logic       timeout,
    output logic       lcd_bus_req,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    input  logic [3:0] lcd_d_in
);

`ifdef LCD_READ_SYNC_EN
    localparam int E_HI_CYC = E_HIGH + 2;
`else
    localparam int E_HI_CYC = E_HIGH;
`endif
    localparam int PH_MAX = (E_SETUP > E_HI_CYC) ? ((E_SETUP > E_LOW) ? E_SETUP : E_LOW)
                                                 : ((E_HI_CYC > E_LOW) ? E_HI_CYC : E_LOW);
    localparam int PH_W = $clog2(PH_MAX + 1);
    localparam int PC_W = $clog2(MAX_POLLS + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        E1_HI = 3'd2,
        E1_LO = 3'd3,
        E2_HI = 3'd4,
        E2_LO = 3'd5,
        CHECK = 3'd6
    } state_t;

    state_t            state_r, state_s;
    logic [PH_W-1:0]   phase_r, phase_lim_s;
    logic              phase_last_s;
    logic [3:0]        cap_hi_r, cap_lo_r, d_cap_s;
    logic              poll_r, poll_s;
    logic [PC_W-1:0]   pcnt_r, pcnt_s;
    logic              accept_s;
    logic              ready_s, rd_valid_s, busy_s, timeout_s;
    logic              bus_s, rs_s, rw_s, e_s;
    logic [7:0]        rd_data_s;

`ifdef LCD_READ_SYNC_EN
    logic [3:0] d_meta_r, d_sync_r;

    // two-flop synchronizer for the LCD data pins
    always_ff @(posedge clock) begin
        if (reset) begin
            d_meta_r <= 4'h0;
            d_sync_r <= 4'h0;
        end else begin
            d_meta_r <= lcd_d_in;
            d_sync_r <= d_meta_r;
        end
    end
    assign d_cap_s = d_sync_r;
`else
    assign d_cap_s = lcd_d_in;
`endif

    // ready is high only in IDLE and in the completing CHECK cycle
    assign accept_s = req & ready;

    // per-state phase length, expressed as the last counter value
    always_comb begin
        phase_lim_s = {PH_W{1'b0}};
        case (state_r)
            SETUP:        phase_lim_s = PH_W'(E_SETUP - 1);
            E1_HI, E2_HI: phase_lim_s = PH_W'(E_HI_CYC - 1);
            E1_LO, E2_LO: phase_lim_s = PH_W'(E_LOW - 1);
            default:      phase_lim_s = {PH_W{1'b0}};
        endcase
    end
    assign phase_last_s = (phase_r == phase_lim_s);

    // next state, poll bookkeeping and next values of all registered outputs
    always_comb begin
        state_s    = state_r;
        poll_s     = poll_r;
        pcnt_s     = pcnt_r;
        ready_s    = ready;
        rd_valid_s = 1'b0;
        rd_data_s  = rd_data;
        busy_s     = busy_flag;
        timeout_s  = timeout;
        bus_s      = lcd_bus_req;
        rs_s       = lcd_rs;
        rw_s       = lcd_rw;
        case (state_r)
            IDLE, CHECK: begin
                if (state_r == CHECK && !rd_valid) begin
                    // poll continues: bus stays owned, RW stays high
                    state_s = SETUP;
                end else if (accept_s) begin
                    state_s = SETUP;
                    rs_s    = req_rs;
                    poll_s  = poll & ~req_rs;
                    rw_s    = 1'b1;
                    bus_s   = 1'b1;
                    ready_s = 1'b0;
                end else begin
                    state_s = IDLE;
                    rw_s    = 1'b0;
                    bus_s   = 1'b0;
                    ready_s = 1'b1;
                end
            end
            SETUP: begin
                if (phase_last_s) state_s = E1_HI;
                else              state_s = SETUP;
            end
            E1_HI: begin
                if (phase_last_s) state_s = E1_LO;
                else              state_s = E1_HI;
            end
            E1_LO: begin
                if (phase_last_s) state_s = E2_HI;
                else              state_s = E1_LO;
            end
            E2_HI: begin
                if (phase_last_s) state_s = E2_LO;
                else              state_s = E2_HI;
            end
            E2_LO: begin
                if (phase_last_s) begin
                    state_s = CHECK;
                    if (poll_r && cap_hi_r[3] && (pcnt_r < PC_W'(MAX_POLLS - 1))) begin
                        pcnt_s = pcnt_r + PC_W'(1);
                    end else begin
                        rd_valid_s = 1'b1;
                        ready_s    = 1'b1;
                        rw_s       = 1'b0;
                        bus_s      = 1'b0;
                        rd_data_s  = {cap_hi_r, cap_lo_r};
                        busy_s     = ~lcd_rs & cap_hi_r[3];
                        timeout_s  = poll_r & cap_hi_r[3];
                        pcnt_s     = {PC_W{1'b0}};
                    end
                end else begin
                    state_s = E2_LO;
                end
            end
            default: begin
                state_s = IDLE;
                rw_s    = 1'b0;
                bus_s   = 1'b0;
                ready_s = 1'b1;
            end
        endcase
        e_s = (state_s == E1_HI) || (state_s == E2_HI);
    end

    // state, phase counter and poll counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            phase_r <= {PH_W{1'b0}};
            poll_r  <= 1'b0;
            pcnt_r  <= {PC_W{1'b0}};
        end else begin
            state_r <= state_s;
            poll_r  <= poll_s;
            pcnt_r  <= pcnt_s;
            if (state_s != state_r || state_r == IDLE) phase_r <= {PH_W{1'b0}};
            else                                       phase_r <= phase_r + PH_W'(1);
        end
    end

    // nibble capture on the last E-high cycle of each strobe
    always_ff @(posedge clock) begin
        if (reset) begin
            cap_hi_r <= 4'h0;
            cap_lo_r <= 4'h0;
        end else begin
            if (state_r == E1_HI && phase_last_s) cap_hi_r <= d_cap_s;
            if (state_r == E2_HI && phase_last_s) cap_lo_r <= d_cap_s;
        end
    end

    // registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            ready       <= 1'b1;
            rd_valid    <= 1'b0;
            rd_data     <= 8'h00;
            busy_flag   <= 1'b0;
            timeout     <= 1'b0;
            lcd_bus_req <= 1'b0;
            lcd_rs      <= 1'b0;
            lcd_rw      <= 1'b0;
            lcd_e       <= 1'b0;
        end else begin
            ready       <= ready_s;
            rd_valid    <= rd_valid_s;
            rd_data     <= rd_data_s;
            busy_flag   <= busy_s;
            timeout     <= timeout_s;
            lcd_bus_req <= bus_s;
            lcd_rs      <= rs_s;
            lcd_rw      <= rw_s;
            lcd_e       <= e_s;
        end
    end

endmodule

// File: tb/tb_lcd_reader.sv
// tb_lcd_reader: self-checking bench for lcd_reader. An LCD model answers each
// E strobe from a nibble queue; a scoreboard holds the expected result of each
// read and is checked whenever rd_valid pulses.
module tb_lcd_reader;
    localparam int ES = 2;
`ifdef LCD_READ_SYNC_EN
    localparam int EH = 17;
`else
    localparam int EH = 15;
`endif
    localparam int EL  = 10;
    localparam int LAT = ES + 2*EH + 2*EL + 1;
    localparam int MP  = 4;

    logic       clock, reset, req, req_rs, poll;
    logic       ready, rd_valid, busy_flag, timeout;
    logic       lcd_bus_req, lcd_rs, lcd_rw, lcd_e;
    logic [7:0] rd_data;
    logic [3:0] lcd_d_in;

    lcd_reader #(.E_SETUP(ES), .E_HIGH(15), .E_LOW(EL), .MAX_POLLS(MP)) dut (
        .clock(clock), .reset(reset), .req(req), .req_rs(req_rs), .poll(poll),
        .ready(ready), .rd_valid(rd_valid), .rd_data(rd_data), .busy_flag(busy_flag),
        .timeout(timeout), .lcd_bus_req(lcd_bus_req), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_e(lcd_e), .lcd_d_in(lcd_d_in)
    );

    typedef struct {
        logic [7:0] data;
        logic       bf;
        logic       to;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [3:0] nib_q[$];
    logic [3:0] cur_nib;
    int errors = 0, checks = 0, cyc = 0, e_rises = 0, underflow = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic exp_t mk_exp(input logic [7:0] d, input logic bf, input logic to, input int c);
        exp_t e;
        e.data = d; e.bf = bf; e.to = to; e.cyc = c;
        return e;
    endfunction

    // LCD model: garbage for the first cycles of each strobe, then the nibble
    always begin
        @(posedge lcd_e);
        e_rises++;
        if (nib_q.size() > 0) begin
            cur_nib = nib_q.pop_front();
        end else begin
            cur_nib = 4'h0;
            underflow++;
        end
        lcd_d_in = ~cur_nib;
        repeat (5) @(posedge clock);
        if (lcd_e) lcd_d_in = cur_nib;
        if (lcd_e) @(negedge lcd_e);
        lcd_d_in = ~cur_nib;
    end

    // scoreboard monitor
    always @(negedge clock) begin
        if (!reset && rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rd_valid: rd_valid=1 at cycle %0d, required no pending read", cyc);
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if (rd_data !== mon_e.data) begin
                    errors++; $display("FAIL rd_data: got %h, want %h", rd_data, mon_e.data);
                end
                checks++;
                if (busy_flag !== mon_e.bf) begin
                    errors++; $display("FAIL busy_flag: got %b, want %b", busy_flag, mon_e.bf);
                end
                checks++;
                if (timeout !== mon_e.to) begin
                    errors++; $display("FAIL timeout: got %b, want %b", timeout, mon_e.to);
                end
                checks++;
                if (cyc !== mon_e.cyc) begin
                    errors++; $display("FAIL latency: rd_valid at cycle %0d, want %0d", cyc, mon_e.cyc);
                end
                checks++;
                if ({ready, lcd_rw, lcd_bus_req} !== 3'b100) begin
                    errors++; $display("FAIL valid_cycle_ctrl: ready/rw/bus_req=%b, want 100", {ready, lcd_rw, lcd_bus_req});
                end
            end
        end
    end

    task automatic start_read(input logic rs, input logic pl, output int acc);
        @(negedge clock);
        req = 1'b1; req_rs = rs; poll = pl;
        @(posedge clock);
        #1;
        acc = cyc;
        req = 1'b0; poll = 1'b0;
    endtask

    task automatic wait_empty(input int budget, output bit ok);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        ok = (sb.size() == 0);
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b0; req_rs = 1'b0; poll = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({ready, rd_valid, busy_flag, timeout} !== 4'b1000) begin
            errors++; $display("FAIL reset_status: ready/valid/bf/to=%b, want 1000", {ready, rd_valid, busy_flag, timeout});
        end
        checks++;
        if ({lcd_bus_req, lcd_rs, lcd_rw, lcd_e} !== 4'b0000) begin
            errors++; $display("FAIL reset_lcd: bus/rs/rw/e=%b, want 0000", {lcd_bus_req, lcd_rs, lcd_rw, lcd_e});
        end
        checks++;
        if (rd_data !== 8'h00) begin
            errors++; $display("FAIL reset_data: got %h, want 00", rd_data);
        end
        reset = 1'b0;
    endtask

    // single read with a cycle-exact trace of RS/RW/E
    task automatic run_traced(input logic rs, input logic pl, input logic [7:0] d, input logic bf, input string nm);
        int acc, e0, bad_rw, bad_e, bad_rs, first_bad;
        logic exp_e;
        bit ok;
        bad_rw = 0; bad_e = 0; bad_rs = 0; first_bad = 0;
        e0 = e_rises;
        nib_q.push_back(d[7:4]); nib_q.push_back(d[3:0]);
        start_read(rs, pl, acc);
        sb.push_back(mk_exp(d, bf, 1'b0, acc + LAT - 1));
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clock);
            exp_e = (c > ES && c <= ES + EH) || (c > ES + EH + EL && c <= ES + 2*EH + EL);
            if (lcd_rw !== (c < LAT)) begin bad_rw++; if (first_bad == 0) first_bad = c; end
            if (lcd_e !== exp_e)      begin bad_e++;  if (first_bad == 0) first_bad = c; end
            if (lcd_rs !== rs)        begin bad_rs++; if (first_bad == 0) first_bad = c; end
        end
        checks++;
        if (bad_rw + bad_e + bad_rs != 0) begin
            errors++;
            $display("FAIL %s_trace: rw/e/rs bad cycles %0d/%0d/%0d (first at cycle %0d), want 0/0/0", nm, bad_rw, bad_e, bad_rs, first_bad);
        end
        wait_empty(5*LAT, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL %s_done: no rd_valid within bound, want one", nm); end
        checks++;
        if (e_rises - e0 != 2) begin errors++; $display("FAIL %s_strobes: %0d E pulses, want 2", nm, e_rises - e0); end
    endtask

    task automatic test_bf_read();
        run_traced(1'b0, 1'b0, 8'h3A, 1'b0, "bf_read");
    endtask

    task automatic test_data_read();
        // BF bit set and poll requested: both must be ignored for a data read
        run_traced(1'b1, 1'b1, 8'hC1, 1'b0, "data_read");
    endtask

    task automatic test_poll(input bit to_case);
        int acc, e0, bad_rw;
        bit ok;
        bad_rw = 0;
        e0 = e_rises;
        for (int i = 0; i < 3; i++) begin nib_q.push_back(4'h8); nib_q.push_back(4'h0); end
        if (to_case) begin nib_q.push_back(4'h8); nib_q.push_back(4'h0); end
        else         begin nib_q.push_back(4'h0); nib_q.push_back(4'h5); end
        start_read(1'b0, 1'b1, acc);
        sb.push_back(mk_exp(to_case ? 8'h80 : 8'h05, to_case, to_case, acc + 4*LAT - 1));
        for (int c = 1; c < 4*LAT; c++) begin
            @(negedge clock);
            if (lcd_rw !== 1'b1 || lcd_bus_req !== 1'b1) bad_rw++;
        end
        checks++;
        if (bad_rw != 0) begin errors++; $display("FAIL poll%0d_rw_held: %0d cycles with rw/bus_req low, want 0", to_case, bad_rw); end
        wait_empty(2*LAT, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL poll%0d_done: no rd_valid within bound, want one", to_case); end
        repeat (LAT) @(negedge clock);
        checks++;
        if (e_rises - e0 != 8) begin errors++; $display("FAIL poll%0d_reads: %0d E pulses, want 8", to_case, e_rises - e0); end
        checks++;
        if (lcd_bus_req !== 1'b0) begin errors++; $display("FAIL poll%0d_idle: bus_req=%b, want 0", to_case, lcd_bus_req); end
    endtask

    task automatic test_back_to_back();
        int acc1, acc2;
        bit ok;
        nib_q.push_back(4'h1); nib_q.push_back(4'h2);
        nib_q.push_back(4'h3); nib_q.push_back(4'h4);
        start_read(1'b0, 1'b0, acc1);
        sb.push_back(mk_exp(8'h12, 1'b0, 1'b0, acc1 + LAT - 1));
        for (int c = 1; c < LAT; c++) begin
            @(negedge clock);
            if (c == 10) req = 1'b1;
            if (c == 11) req = 1'b0;
        end
        @(negedge clock);
        req = 1'b1; req_rs = 1'b0; poll = 1'b0;
        @(posedge clock);
        #1;
        acc2 = cyc;
        req = 1'b0;
        sb.push_back(mk_exp(8'h34, 1'b0, 1'b0, acc2 + LAT - 1));
        checks++;
        if (acc2 - acc1 != LAT) begin errors++; $display("FAIL b2b_accept: second accept %0d cycles after first, want %0d", acc2 - acc1, LAT); end
        @(negedge clock);
        checks++;
        if ({lcd_bus_req, lcd_rw, ready} !== 3'b110) begin
            errors++; $display("FAIL b2b_setup: bus/rw/ready=%b, want 110", {lcd_bus_req, lcd_rw, ready});
        end
        wait_empty(2*LAT, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_done: results pending %0d, want 0", sb.size()); end
    endtask

    task automatic test_reset_midop();
        int acc;
        nib_q.push_back(4'h7); nib_q.push_back(4'h7);
        start_read(1'b1, 1'b0, acc);
        for (int c = 1; c <= 38; c++) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({lcd_e, lcd_rw, lcd_bus_req, lcd_rs, ready, rd_valid} !== 6'b000010) begin
            errors++; $display("FAIL midop_reset: e/rw/bus/rs/ready/valid=%b, want 000010", {lcd_e, lcd_rw, lcd_bus_req, lcd_rs, ready, rd_valid});
        end
        checks++;
        if (rd_data !== 8'h00) begin errors++; $display("FAIL midop_data: got %h, want 00", rd_data); end
        reset = 1'b0;
        repeat (2*LAT) @(negedge clock);
        run_traced(1'b0, 1'b0, 8'h56, 1'b0, "after_reset");
    endtask

    initial begin
        lcd_d_in = 4'hF;
        test_reset();
        test_bf_read();
        test_data_read();
        test_poll(1'b0);
        test_poll(1'b1);
        test_back_to_back();
        test_reset_midop();
        checks++;
        if (nib_q.size() != 0 || underflow != 0) begin
            errors++; $display("FAIL model_balance: %0d nibbles left, %0d underflows, want 0/0", nib_q.size(), underflow);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
